// File: rtl/td4_pkg.sv
// ---------------------------------------------------------------------------
// td4_pkg -- shared definitions for the TD4 program memory block.
//
// Holds the memory geometry (16 x 8), the NOP word that the CPU executes as
// a harmless ADD A,0, and the loader FSM state encoding.
//
// Optional feature macro: TD4_PROG_CHECKSUM_EN
//   defined   -> the state set includes CHECK and ERR (checksum byte stage)
//   undefined -> only IDLE, LOAD and RUN exist
// ---------------------------------------------------------------------------
package td4_pkg;

    localparam int MEM_DEPTH = 16;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);
    localparam int WORD_W    = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [WORD_W-1:0] word_t;

    localparam word_t NOP_WORD = 8'h00;

`ifdef TD4_PROG_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        RUN,
        ERR
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;
`endif

endpackage

// File: rtl/td4_prog_ram.sv
// ---------------------------------------------------------------------------
// td4_prog_ram -- 16 x 8 program storage.
//
// Synchronous write, registered read (one cycle latency) and a full-array
// fill with FILL_WORD on reset.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   i_wr_en    in   write strobe
//   i_wr_addr  in   write address
//   i_wr_data  in   write data
//   i_rd_addr  in   read address, sampled every cycle
//   o_rd_data  out  registered read data
//
// Optional feature macro: none in this file (TD4_PROG_CHECKSUM_EN is handled
// by the top level).
// ---------------------------------------------------------------------------
module td4_prog_ram
    import td4_pkg::*;
#(
    parameter word_t FILL_WORD = NOP_WORD
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_wr_en,
    input  addr_t i_wr_addr,
    input  word_t i_wr_data,
    input  addr_t i_rd_addr,
    output word_t o_rd_data
);

    word_t r_mem [MEM_DEPTH];
    word_t r_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the array is reset on purpose so a half-loaded or
            // never-loaded program reads as a known fill word; this rules
            // out a block-RAM mapping, which is acceptable at 16 entries.
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= FILL_WORD;
            end
            r_rd_data <= NOP_WORD;
        end else begin
            if (i_wr_en) begin
                r_mem[i_wr_addr] <= i_wr_data;
            end
            // Read-before-write: a same-cycle write to i_rd_addr shows up
            // on the following read.
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/td4_prog_mem.sv
// ---------------------------------------------------------------------------
// td4_prog_mem -- TD4 program memory with byte-stream loader.
//
// A host streams 16 program bytes over a valid/ready interface after a
// load_start pulse. Once loaded, the block enters RUN and serves the CPU:
// {opcode, immediate} is mem[pc_in] with one cycle of latency. Outside RUN
// the fetch outputs are forced to zero (ADD A,0).
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset (wins over everything)
//   load_start  in   begin / restart loading (same-cycle transfer ignored)
//   load_valid  in   load_data is valid
//   load_data   in   program byte {opcode[7:4], immediate[3:0]}
//   load_ready  out  byte accepted when load_valid is also high
//   pc_in       in   fetch address from the CPU program counter
//   opcode      out  fetched opcode
//   immediate   out  fetched immediate
//   run         out  program loaded, CPU may execute
//   prog_err    out  checksum mismatch
//
// Optional feature macro: TD4_PROG_CHECKSUM_EN
//   defined   -> a 17th byte must equal the modulo-256 sum of the 16 program
//                bytes; mismatch parks the block in ERR
//   undefined -> RUN follows the 16th byte directly, prog_err is tied to 0
// ---------------------------------------------------------------------------
module td4_prog_mem
    import td4_pkg::*;
#(
    parameter word_t FILL_WORD = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    output logic        load_ready,
    input  logic [3:0]  pc_in,
    output logic [3:0]  opcode,
    output logic [3:0]  immediate,
    output logic        run,
    output logic        prog_err
);

    state_t r_state;
    state_t w_next_state;
    addr_t  r_wr_ptr;
    logic   w_accept;
    logic   w_wr_en;
    word_t  w_rd_data;

`ifdef TD4_PROG_CHECKSUM_EN
    word_t  r_checksum;
`endif

    // -----------------------------------------------------------------------
    // State register and write pointer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments in every clocked block, so all
            // registers update from pre-edge values regardless of order.
            r_state  <= IDLE;
            r_wr_ptr <= '0;
        end else begin
            r_state <= w_next_state;
            if (load_start) begin
                r_wr_ptr <= '0;
            end else if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + addr_t'(1);  // wraps 15 -> 0
            end
        end
    end

`ifdef TD4_PROG_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || load_start) begin
            r_checksum <= '0;
        end else if (w_wr_en) begin
            r_checksum <= r_checksum + load_data;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned and no latch is inferred.
        w_next_state = r_state;
        load_ready   = 1'b0;
        run          = 1'b0;
        prog_err     = 1'b0;
        opcode       = 4'h0;
        immediate    = 4'h0;

`ifdef TD4_PROG_CHECKSUM_EN
        load_ready = (r_state == LOAD) || (r_state == CHECK);
        prog_err   = (r_state == ERR);
`else
        load_ready = (r_state == LOAD);
`endif
        run = (r_state == RUN);

        // load_start claims the cycle: any coincident transfer is dropped.
        w_accept = load_valid && load_ready && !load_start;
        w_wr_en  = w_accept && (r_state == LOAD);

        if (run) begin
            {opcode, immediate} = w_rd_data;
        end

        if (load_start) begin
            w_next_state = LOAD;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_accept && (r_wr_ptr == addr_t'(MEM_DEPTH - 1))) begin
`ifdef TD4_PROG_CHECKSUM_EN
                        w_next_state = CHECK;
`else
                        w_next_state = RUN;
`endif
                    end
                end
`ifdef TD4_PROG_CHECKSUM_EN
                CHECK: begin
                    if (w_accept) begin
                        w_next_state = (load_data == r_checksum) ? RUN : ERR;
                    end
                end
`endif
                default: begin
                    // IDLE, RUN and ERR hold until load_start or rst.
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    td4_prog_ram #(
        .FILL_WORD (FILL_WORD)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (load_data),
        .i_rd_addr (pc_in),
        .o_rd_data (w_rd_data)
    );

endmodule

// File: tb/tb_td4_prog_mem.sv
// ---------------------------------------------------------------------------
// tb_td4_prog_mem -- scoreboard bench for td4_prog_mem.
//
// Stimulus tasks drive inputs just after a rising edge and push the outputs
// expected after the next edge into a queue; a monitor on the falling edge
// pops and compares them. Works with and without TD4_PROG_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_td4_prog_mem;

    localparam logic [7:0] FILL = 8'hA5;

    logic       clk;
    logic       rst;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic [3:0] pc_in;
    logic [3:0] opcode;
    logic [3:0] immediate;
    logic       run;
    logic       prog_err;

    td4_prog_mem #(
        .FILL_WORD (FILL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .pc_in      (pc_in),
        .opcode     (opcode),
        .immediate  (immediate),
        .run        (run),
        .prog_err   (prog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -----------------------------------------------------------------------
    // Scoreboard
    // -----------------------------------------------------------------------
    typedef struct {
        int         cyc;
        string      name;
        bit         chk_fetch;
        logic [7:0] fetch;
        logic       run;
        logic       err;
        logic       rdy;
    } exp_t;

    exp_t sb_q[$];

    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            if (e.cyc < cyc) begin
                check({e.name, " late"}, cyc, e.cyc);
            end else begin
                check({e.name, " run"}, run, e.run);
                check({e.name, " prog_err"}, prog_err, e.err);
                check({e.name, " load_ready"}, load_ready, e.rdy);
                if (e.chk_fetch) begin
                    check({e.name, " fetch"}, {opcode, immediate}, e.fetch);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Reference model of the memory contents and checksum
    // -----------------------------------------------------------------------
    logic [7:0] model_mem [16];
    logic [7:0] model_sum;
    int         model_ptr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input bit chk_fetch, input logic [7:0] fetch,
                              input logic r, input logic e, input logic rdy);
        exp_t x;
        x.cyc       = cyc + 1;
        x.name      = name;
        x.chk_fetch = chk_fetch;
        x.fetch     = fetch;
        x.run       = r;
        x.err       = e;
        x.rdy       = rdy;
        sb_q.push_back(x);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_mem[i] = FILL;
        model_sum = 8'h00;
        model_ptr = 0;
    endtask

    task automatic do_start(input string name, input logic valid, input logic [7:0] data);
        load_start = 1'b1;
        load_valid = valid;
        load_data  = data;
        expect_out(name, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        load_start = 1'b0;
        model_ptr  = 0;
        model_sum  = 8'h00;
    endtask

    task automatic send_byte(input string name, input logic [7:0] data);
        bit last;
        last       = (model_ptr == 15);
        load_valid = 1'b1;
        load_data  = data;
        model_mem[model_ptr] = data;
        model_ptr  = (model_ptr + 1) % 16;
        model_sum  = model_sum + data;
`ifdef TD4_PROG_CHECKSUM_EN
        expect_out(name, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
`else
        if (last) expect_out(name, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        else      expect_out(name, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
`endif
        tick();
    endtask

    task automatic finish_load(input string name);
`ifdef TD4_PROG_CHECKSUM_EN
        load_valid = 1'b1;
        load_data  = model_sum;
        expect_out({name, " checksum ok"}, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
`endif
        load_valid = 1'b0;
    endtask

    task automatic sweep(input string name);
        for (int p = 0; p <= 16; p++) begin
            pc_in = 4'(p);
            expect_out($sformatf("%s pc=%0d", name, p), 1'b1, model_mem[p % 16], 1'b1, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic check_fill(input string name);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s mem[%0d]", name, i), dut.u_ram.r_mem[i], FILL);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        pc_in      = 4'h0;
        model_reset();
        #1;

        // Reset state
        expect_out("reset c0", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("reset c1", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        check_fill("reset");
        rst = 1'b0;

        // IDLE ignores a transfer attempt
        load_valid = 1'b1;
        load_data  = 8'h77;
        expect_out("idle hold", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        load_valid = 1'b0;

        // Full load of C1..CF,C0 then fetch pc=3 -> C4
        do_start("t2 start", 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            send_byte($sformatf("t2 byte%0d", i), {4'hC, 4'(i + 1)});
        end
        finish_load("t2");
        pc_in = 4'd3;
        expect_out("t2 fetch pc3", 1'b1, 8'hC4, 1'b1, 1'b0, 1'b0);
        tick();
        sweep("t2 sweep");

        // Reset in RUN, coincident with load_start and a transfer
        rst        = 1'b1;
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'hFF;
        expect_out("t3 rst in run", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        check_fill("t3 rst in run");
        model_reset();
        rst        = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        expect_out("t3 idle after rst", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();

        // Restart after 5 bytes with load_valid held high
        do_start("t4 start", 1'b1, 8'h20);
        for (int i = 0; i < 5; i++) begin
            send_byte($sformatf("t4 pre%0d", i), 8'h20 + 8'(i));
        end
        do_start("t4 restart", 1'b1, 8'h99);
        for (int i = 0; i < 16; i++) begin
            send_byte($sformatf("t4 byte%0d", i), 8'h30 + 8'(i));
        end
        finish_load("t4");
        sweep("t4 sweep");

        // load_valid toggling: gaps must not advance the pointer
        do_start("t5 start", 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            send_byte($sformatf("t5 byte%0d", i), 8'h50 + 8'(i));
            if (i != 15) begin
                load_valid = 1'b0;
                load_data  = 8'hEE;
                expect_out($sformatf("t5 gap%0d", i), 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
                tick();
            end
        end
        finish_load("t5");
        sweep("t5 sweep");

`ifdef TD4_PROG_CHECKSUM_EN
        // Wrong checksum -> ERR, then restart clears prog_err
        do_start("t6 start", 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            send_byte($sformatf("t6 byte%0d", i), 8'h11);
        end
        load_valid = 1'b1;
        load_data  = 8'h00;
        expect_out("t6 bad checksum", 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        load_valid = 1'b0;
        pc_in      = 4'd5;
        expect_out("t6 err hold", 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        do_start("t6 restart", 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            send_byte($sformatf("t6 reload%0d", i), 8'h11);
        end
        load_valid = 1'b1;
        load_data  = 8'h10;
        expect_out("t6 good checksum", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        load_valid = 1'b0;
        sweep("t6 sweep");
`endif

        // Reset mid-load: no resume afterwards
        do_start("t7 start", 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            send_byte($sformatf("t7 byte%0d", i), 8'h60 + 8'(i));
        end
        rst        = 1'b1;
        load_valid = 1'b0;
        expect_out("t7 rst mid-load", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        check_fill("t7 rst mid-load");
        rst        = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'h77;
        expect_out("t7 no resume", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        load_valid = 1'b0;

        tick();
        tick();
        check("scoreboard drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/td4_prog_mem.md
TD4_PROG_MEM -- requirements
Module: td4_prog_mem

Interface
REQ-001 SHALL have parameter FILL_WORD, default 8'h00, meaning the value written to every memory entry on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port load_start  input  1  one-cycle request to begin (or restart) program loading.
REQ-005 SHALL have port load_valid  input  1  load_data carries a valid byte.
REQ-006 SHALL have port load_data  input  8  program byte; [7:4] is the opcode and [3:0] is the immediate.
REQ-007 SHALL have port load_ready  output  1  block accepts a byte this cycle.
REQ-008 SHALL have port pc_in  input  4  fetch address driven by the CPU program counter.
REQ-009 SHALL have port opcode  output  4  fetched opcode, which feeds the CPU.
REQ-010 SHALL have port immediate  output  4  fetched immediate, which feeds the CPU.
REQ-011 SHALL have port run  output  1  program loaded; the CPU may execute.
REQ-012 SHALL have port prog_err  output  1  load failed (checksum build only).

Function
REQ-013 SHALL implement a 16 x 8 memory, with a 4-bit write pointer wr_ptr and FSM states IDLE, LOAD, CHECK, RUN and ERR.
REQ-014 SHALL transfer a byte only when load_valid and load_ready are both 1 on a rising edge.
REQ-015 SHALL drive load_ready=1 only in LOAD and CHECK.
REQ-016 SHALL, on load_start=1 in any state, go to LOAD, clear wr_ptr to 0 and clear prog_err; any transfer in that same cycle is ignored.
REQ-017 SHALL, in LOAD, write each accepted byte to mem[wr_ptr] and then increment wr_ptr.
REQ-018 SHALL, on the accept at wr_ptr=15, go to CHECK when TD4_PROG_CHECKSUM_EN is defined and to RUN otherwise; wr_ptr wraps to 0.
REQ-019 SHALL, in CHECK, accept exactly one byte and compare it with the checksum: match goes to RUN, mismatch goes to ERR.
REQ-020 SHALL hold RUN and ERR until load_start or rst arrives; IDLE likewise waits for load_start.
REQ-021 SHALL drive run=1 only in RUN, and prog_err=1 only in ERR.
REQ-022 SHALL register the fetch output: in RUN, {opcode,immediate} at edge N+1 equals mem[pc_in] sampled at edge N, so fetch latency is one cycle.
REQ-023 SHALL force opcode and immediate to 0 in every state other than RUN, which the CPU treats as a harmless ADD A,0.
REQ-024 SHALL make pc_in wrap implicitly: address 15 is followed by 0, with no special handling.
REQ-025 SHALL leave memory unchanged by pc_in or fetch activity; memory is written only by LOAD accepts and by reset.

Reset
REQ-026 SHALL, when rst=1 at a rising edge, set state=IDLE, wr_ptr=0, checksum=0, every mem entry=FILL_WORD, opcode=0, immediate=0, run=0, prog_err=0 and load_ready=0.
REQ-027 SHALL give rst priority over load_start and load transfers.
REQ-028 SHALL abandon a partial load on reset mid-load; it does not resume.

Configuration
REQ-029 SHALL, when macro TD4_PROG_CHECKSUM_EN is defined, keep an 8-bit modulo-256 sum of the 16 program bytes (cleared on load_start and on rst) and use CHECK and ERR.
REQ-030 SHALL, without TD4_PROG_CHECKSUM_EN, omit the checksum register, CHECK and ERR, and tie prog_err to 0.

Structure
REQ-031 SHALL take the FSM state enum, the memory depth (16), the word width (8) and the NOP word (8'h00) from shared package td4_pkg.
REQ-032 SHALL contain one sub-module, td4_prog_ram: a 16x8 storage array with synchronous write, a registered read port and reset fill.

Verification
REQ-033 SHALL cover: rst, then load_start, then 16 bytes 8'hC1..8'hC? and sum checksum -> run=1 after the final accept, and pc_in=3 yields opcode=4'hC, immediate=mem[3][3:0] one cycle later.
REQ-034 SHALL cover: load_valid=1 continuously with load_start re-asserted after 5 bytes -> wr_ptr restarts at 0, bytes 0..4 are overwritten, and the load completes after 16 further accepts.
REQ-035 SHALL cover (checksum build): 16 bytes of 8'h11 followed by checksum 8'h00 (correct value 8'h10) -> ERR, prog_err=1, run=0 and opcode/immediate=0.
REQ-036 SHALL cover: rst=1 for one cycle while in RUN -> every output is 0, memory reads FILL_WORD, and state is IDLE on the next cycle.
REQ-037 SHALL cover: in RUN, pc_in sweeping 0..15 and then 0 -> the outputs track mem[0..15] and then mem[0] with one-cycle latency, including the 15 to 0 wrap.
REQ-038 SHALL cover: load_valid toggling 1,0,1 in LOAD -> only cycles with valid=1 advance wr_ptr, and there are no duplicate writes.
